// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
//   - op encodings driven by the decoder for mult/div/mthi/mtlo
//   - default latencies for the multiply and divide paths
//   - divide-by-zero result constant (HI takes the dividend unchanged)
//   - FSM state type and op-class helpers
package mips_muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam int unsigned DEF_MUL_CYCLES = 5;
    localparam int unsigned DEF_DIV_CYCLES = 10;

    // Divide by zero: LO saturates to all ones, HI returns the dividend.
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    typedef enum logic [0:0] {StIdle, StRun} md_state_e;

    function automatic logic is_mul_op(logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div_op(logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
//   start  operation valid this cycle
//   op     3-bit op code (see mips_muldiv_pkg)
//   A, B   rs / rt operands
//   busy   unit has a MULT/DIV in flight
//   HIO    HI register value
//   LOO    LO register value
// master: the EX stage / hazard side; slave: muldiv_unit.
interface muldiv_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HIO;
    logic [31:0] LOO;

    modport master (output start, op, A, B, input busy, HIO, LOO);
    modport slave  (input start, op, A, B, output busy, HIO, LOO);
endinterface

// File: rtl/muldiv_arith.sv
// Purely combinational arithmetic core for MULT/MULTU/DIV/DIVU.
//   op      in   3   op code
//   A, B    in   32  operands
//   res_hi  out  32  HI result (product high word / remainder)
//   res_lo  out  32  LO result (product low word / quotient)
// Divide by zero yields LO=all ones, HI=A. The signed overflow case
// 0x8000_0000 / -1 falls out of the magnitude path as LO=0x8000_0000, HI=0.
// Non-arithmetic ops produce zero.
module muldiv_arith
    import mips_muldiv_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic        is_signed;
    logic [63:0] a_ext, b_ext, prod;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag, quot, rem;

    assign is_signed = (op == OP_MULT) || (op == OP_DIV);

    // Low 64 bits of an extended product are correct for both signednesses.
    assign a_ext = is_signed ? {{32{A[31]}}, A} : {32'h0, A};
    assign b_ext = is_signed ? {{32{B[31]}}, B} : {32'h0, B};
    assign prod  = a_ext * b_ext;

    // Signed divide via magnitudes: quotient truncates toward zero,
    // remainder follows the dividend's sign.
    assign a_neg = is_signed & A[31];
    assign b_neg = is_signed & B[31];
    assign a_mag = a_neg ? (32'd0 - A) : A;
    assign b_mag = b_neg ? (32'd0 - B) : B;
    assign b_div = (B == 32'd0) ? 32'd1 : b_mag;
    assign q_mag = a_mag / b_div;
    assign r_mag = a_mag % b_div;
    assign quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem   = a_neg ? (32'd0 - r_mag) : r_mag;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        if (is_mul_op(op)) begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end else if (is_div_op(op)) begin
            if (B == 32'd0) begin
                res_hi = A;
                res_lo = DIV0_LO;
            end else begin
                res_hi = rem;
                res_lo = quot;
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers (EX stage).
//   clk    in   clock, rising edge
//   reset  in   synchronous active-high reset
//   bus    muldiv_unit_if.slave: start/op/A/B in; busy/HIO/LOO out
// The result is computed at the accept edge and parked in pend_hi/pend_lo;
// HI/LO only change at the commit edge N cycles later, so the visible
// registers never show a partial result. All outputs are registers.
module muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int unsigned DIV_CYCLES = DEF_DIV_CYCLES
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);

    localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      res_hi, res_lo;

    muldiv_arith u_arith (
        .op     (bus.op),
        .A      (bus.A),
        .B      (bus.B),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            pend_hi_d = res_hi;
                            pend_lo_d = res_lo;
                            cnt_d     = CNT_W'(MUL_CYCLES - 1);
                            state_d   = StRun;
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_hi_d = res_hi;
                            pend_lo_d = res_lo;
                            cnt_d     = CNT_W'(DIV_CYCLES - 1);
                            state_d   = StRun;
                        end
                        OP_MTHI: hi_d = bus.A;
                        OP_MTLO: lo_d = bus.A;
                        default: ;
                    endcase
                end
            end
            StRun: begin
                // start is ignored throughout RUN, including the commit edge.
                if (cnt_q == '0) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy = (state_q == StRun);
    assign bus.HIO  = hi_q;
    assign bus.LOO  = lo_q;

endmodule
